byte_to_smp: RTL and testbench

Receive-side counterpart of the ILA sample serializer. It collects 8-bit packets arriving from the SPI slave interface and assembles them into one word of arbitrary width. Packets arrive LSB-byte-first, zero-padded in the top byte, with the same framing the sample-to-byte path uses on transmit. The assembled word feeds configuration and trigger-pattern registers, with a completion strobe and a completed-word counter.

---
 rtl/byte_to_smp.sv | 206 ++++++++++++++++++++
 tb/tb_byte_to_smp.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_to_smp.sv
// -----------------------------------------------------------------------------
// byte_to_smp
//
// Receive-side counterpart of the ILA sample serializer. It collects the 8-bit
// packets delivered by the SPI slave and assembles them into one word of
// word_width bits. Packets arrive LSB byte first. The top byte is zero-padded,
// so the last byte's top (bytes_per_word*8 - word_width) bits are dropped
// without being checked. Completed words go to the configuration and
// trigger-pattern registers. Each completion produces a strobe and advances a
// wrapping counter.
//
// Optional feature (define BYTE_TO_SMP_CHECKSUM_EN):
//   Every word is followed by one checksum byte. It is the XOR of the word's
//   data bytes. A word is published only when the checksum matches. A mismatch
//   pulses o_chk_err and leaves o_word untouched.
//
// Parameters:
//   word_width  width of the assembled word in bits (>= 1)
//   cnt_width   width of the completed-word counter (wraps)
//
// Ports:
//   i_clk_ILA       ILA clock; all logic is rising-edge
//   i_reset         asynchronous, active-high reset
//   i_frame_active  high while a host transfer is in progress; low aborts
//   i_byte          received byte, sampled only when i_byte_stb = 1
//   i_byte_stb      one-cycle strobe: i_byte is valid
//   o_word          last completed word; holds between completions
//   o_word_valid    one-cycle pulse: o_word updated this cycle
//   o_partial_drop  one-cycle pulse: frame ended with a partial word
//   o_word_cnt      completed words since reset, modulo 2**cnt_width
//   o_chk_err       (checksum build only) one-cycle pulse: checksum mismatch
// -----------------------------------------------------------------------------
module byte_to_smp #(
  parameter int word_width = 24,
  parameter int cnt_width  = 8
) (
  input  logic                  i_clk_ILA,
  input  logic                  i_reset,
  input  logic                  i_frame_active,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_stb,
  output logic [word_width-1:0] o_word,
  output logic                  o_word_valid,
  output logic                  o_partial_drop,
  output logic [cnt_width-1:0]  o_word_cnt
`ifdef BYTE_TO_SMP_CHECKSUM_EN
  ,
  output logic                  o_chk_err
`endif
);

  localparam int bytes_per_word = ((word_width - 1) / 8) + 1;
  localparam int shift_width    = bytes_per_word * 8;
  localparam int bcnt_width     = $clog2(bytes_per_word + 1);
  localparam logic [bcnt_width-1:0] last_idx = bcnt_width'(bytes_per_word - 1);

`ifdef BYTE_TO_SMP_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_CHECK} state_t;
`else
  typedef enum logic {ST_IDLE, ST_COLLECT} state_t;
`endif

  state_t                  state_q, state_d;
  logic [bcnt_width-1:0]   bcnt_q, bcnt_d;
  logic [shift_width-1:0]  shift_q, shift_d;
  logic [shift_width-1:0]  shift_push;
  logic [word_width-1:0]   word_d;
  logic                    word_done;
  logic                    drop;
  logic                    take;
  logic                    last_byte;
`ifdef BYTE_TO_SMP_CHECKSUM_EN
  logic [7:0]              xor_q, xor_d;
  logic                    chk_err;
`endif

  // New bytes enter at the top and move down. After bytes_per_word strobes,
  // the first byte has reached bits [7:0].
  generate
    if (bytes_per_word == 1) begin : g_one_byte
      assign shift_push = i_byte;
    end else begin : g_multi_byte
      assign shift_push = {i_byte, shift_q[shift_width-1:8]};
    end
  endgenerate

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    word_d    = shift_push[word_width-1:0];
    word_done = 1'b0;
    drop      = 1'b0;
    take      = 1'b0;
    last_byte = (bcnt_q == last_idx);
`ifdef BYTE_TO_SMP_CHECKSUM_EN
    xor_d     = xor_q;
    chk_err   = 1'b0;
`endif

    unique case (state_q)
      // IDLE always holds a zero count. So a strobe that arrives together with
      // the frame's rising edge is simply byte 0 of a fresh word.
      ST_IDLE, ST_COLLECT: begin
`ifdef BYTE_TO_SMP_CHECKSUM_EN
        take = i_byte_stb && i_frame_active;
`else
        // When the final byte coincides with the frame falling, the word is
        // still completed.
        take = i_byte_stb &&
               (i_frame_active || (state_q == ST_COLLECT && last_byte));
`endif
        if (i_frame_active) state_d = ST_COLLECT;

        if (take) begin
          shift_d = shift_push;
`ifdef BYTE_TO_SMP_CHECKSUM_EN
          xor_d  = xor_q ^ i_byte;
          bcnt_d = bcnt_q + bcnt_width'(1);
          if (last_byte) state_d = ST_CHECK;
`else
          if (last_byte) begin
            word_done = 1'b1;
            bcnt_d    = '0;
          end else begin
            bcnt_d = bcnt_q + bcnt_width'(1);
          end
`endif
        end

        if (!i_frame_active) begin
          drop    = !take && (bcnt_q != '0);
          state_d = ST_IDLE;
          bcnt_d  = '0;
          shift_d = '0;
`ifdef BYTE_TO_SMP_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end

`ifdef BYTE_TO_SMP_CHECKSUM_EN
      // The shift register already holds all the data bytes. Only the
      // checksum byte is still outstanding.
      ST_CHECK: begin
        if (i_byte_stb) begin
          word_d = shift_q[word_width-1:0];
          if (i_byte == xor_q) word_done = 1'b1;
          else                 chk_err   = 1'b1;
          bcnt_d = '0;
          xor_d  = '0;
          if (i_frame_active) begin
            state_d = ST_COLLECT;
          end else begin
            state_d = ST_IDLE;
            shift_d = '0;
          end
        end else if (!i_frame_active) begin
          drop    = 1'b1;
          state_d = ST_IDLE;
          bcnt_d  = '0;
          shift_d = '0;
          xor_d   = '0;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the statements appear in.
  always_ff @(posedge i_clk_ILA or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= ST_IDLE;
      bcnt_q         <= '0;
      shift_q        <= '0;
      o_word         <= '0;
      o_word_valid   <= 1'b0;
      o_partial_drop <= 1'b0;
      o_word_cnt     <= '0;
`ifdef BYTE_TO_SMP_CHECKSUM_EN
      xor_q          <= '0;
      o_chk_err      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      bcnt_q         <= bcnt_d;
      shift_q        <= shift_d;
      o_word_valid   <= word_done;
      o_partial_drop <= drop;
      if (word_done) begin
        o_word     <= word_d;
        o_word_cnt <= o_word_cnt + cnt_width'(1);
      end
`ifdef BYTE_TO_SMP_CHECKSUM_EN
      xor_q          <= xor_d;
      o_chk_err      <= chk_err;
`endif
    end
  end

endmodule

// File: tb/tb_byte_to_smp.sv
// -----------------------------------------------------------------------------
// tb_byte_to_smp
//
// Two instances share one byte stream:
//   dut_a: word_width=24, cnt_width=8 (3 bytes per word)
//   dut_b: word_width=12, cnt_width=2 (2 bytes per word, padded, wrapping cnt)
// A frame-level reference model collects the accepted bytes of each frame in a
// queue. It predicts every output pulse, together with the expected word and
// count. Those predictions go into per-instance queues. A negedge monitor pops
// them and compares them against the pulses the DUTs present.
// -----------------------------------------------------------------------------
module tb_byte_to_smp;

`ifdef BYTE_TO_SMP_CHECKSUM_EN
  localparam int chk_en = 1;
`else
  localparam int chk_en = 0;
`endif

  localparam logic [2:0] EV_WORD = 3'b001;
  localparam logic [2:0] EV_DROP = 3'b010;
  localparam logic [2:0] EV_CERR = 3'b100;

  typedef struct {
    int          cyc;
    logic [2:0]  kind;
    logic [31:0] word;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame;
  logic        stb;
  logic [7:0]  byte_in;

  logic [23:0] a_word;
  logic        a_valid, a_drop, a_chk;
  logic [7:0]  a_cnt;
  logic [11:0] b_word;
  logic        b_valid, b_drop, b_chk;
  logic [1:0]  b_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state, one slot per instance.
  int          bpw     [2] = '{3, 2};
  logic [31:0] mask    [2] = '{32'hFF_FFFF, 32'hFFF};
  int          cnt_mod [2] = '{256, 4};
  logic [7:0]  fb      [2][$];
  bit          in_frame[2];
  logic [31:0] m_word  [2];
  logic [31:0] m_cnt   [2];
  exp_t        exp_q   [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  byte_to_smp #(.word_width(24), .cnt_width(8)) dut_a (
    .i_clk_ILA      (clk),
    .i_reset        (rst),
    .i_frame_active (frame),
    .i_byte         (byte_in),
    .i_byte_stb     (stb),
    .o_word         (a_word),
    .o_word_valid   (a_valid),
    .o_partial_drop (a_drop),
    .o_word_cnt     (a_cnt)
`ifdef BYTE_TO_SMP_CHECKSUM_EN
    ,
    .o_chk_err      (a_chk)
`endif
  );

  byte_to_smp #(.word_width(12), .cnt_width(2)) dut_b (
    .i_clk_ILA      (clk),
    .i_reset        (rst),
    .i_frame_active (frame),
    .i_byte         (byte_in),
    .i_byte_stb     (stb),
    .o_word         (b_word),
    .o_word_valid   (b_valid),
    .o_partial_drop (b_drop),
    .o_word_cnt     (b_cnt)
`ifdef BYTE_TO_SMP_CHECKSUM_EN
    ,
    .o_chk_err      (b_chk)
`endif
  );

`ifndef BYTE_TO_SMP_CHECKSUM_EN
  assign a_chk = 1'b0;
  assign b_chk = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void push_ev(int d, logic [2:0] k);
    exp_t e;
    e.cyc  = cyc + 1;
    e.kind = k;
    e.word = m_word[d];
    e.cnt  = m_cnt[d];
    exp_q[d].push_back(e);
  endfunction

  function automatic void finish_word(int d);
    logic [31:0] w = 32'h0;
    logic [7:0]  x = 8'h0;
    bit          ok = 1'b1;
    for (int i = 0; i < bpw[d]; i++) begin
      w = w | (32'(fb[d][i]) << (8 * i));
      x = x ^ fb[d][i];
    end
    if (chk_en != 0) begin
      if (fb[d][bpw[d]] != x) ok = 1'b0;
    end
    if (ok) begin
      m_word[d] = w & mask[d];
      m_cnt[d]  = (m_cnt[d] + 1) % cnt_mod[d];
      push_ev(d, EV_WORD);
    end else begin
      push_ev(d, EV_CERR);
    end
    fb[d].delete();
  endfunction

  function automatic void model_step(int d, bit f, bit s, logic [7:0] b);
    int need = bpw[d] + chk_en;
    if (f) begin
      in_frame[d] = 1'b1;
      if (s) begin
        fb[d].push_back(b);
        if (fb[d].size() == need) finish_word(d);
      end
    end else begin
      // A closing byte that arrives with the frame's falling edge still counts.
      if (s && in_frame[d] && fb[d].size() == need - 1) begin
        fb[d].push_back(b);
        finish_word(d);
      end else if (fb[d].size() != 0) begin
        push_ev(d, EV_DROP);
      end
      fb[d].delete();
      in_frame[d] = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      fb[d].delete();
      exp_q[d].delete();
      in_frame[d] = 1'b0;
      m_word[d]   = 32'h0;
      m_cnt[d]    = 32'h0;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1. Applies one cycle of inputs and returns at the next
  // posedge+1, when the DUT outputs reflect those inputs.
  task automatic drive(input bit f, input bit s, input logic [7:0] b);
    frame   = f;
    stb     = s;
    byte_in = b;
    model_step(0, f, s, b);
    model_step(1, f, s, b);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    frame = 1'b0;
    stb   = 1'b0;
    #1;
    check("rst_a_word",  32'(a_word),  32'h0);
    check("rst_a_valid", 32'(a_valid), 32'h0);
    check("rst_a_drop",  32'(a_drop),  32'h0);
    check("rst_a_cnt",   32'(a_cnt),   32'h0);
    check("rst_b_word",  32'(b_word),  32'h0);
    check("rst_b_valid", 32'(b_valid), 32'h0);
    check("rst_b_drop",  32'(b_drop),  32'h0);
    check("rst_b_cnt",   32'(b_cnt),   32'h0);
`ifdef BYTE_TO_SMP_CHECKSUM_EN
    check("rst_a_chk",   32'(a_chk),   32'h0);
    check("rst_b_chk",   32'(b_chk),   32'h0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [2:0]  ev;
    logic [2:0]  ek;
    logic [31:0] w;
    logic [31:0] c;
    bit          has;
    exp_t        e;
    string       p;
    for (int d = 0; d < 2; d++) begin
      p   = (d == 0) ? "a" : "b";
      ev  = (d == 0) ? {a_chk, a_drop, a_valid} : {b_chk, b_drop, b_valid};
      w   = (d == 0) ? 32'(a_word) : 32'(b_word);
      c   = (d == 0) ? 32'(a_cnt)  : 32'(b_cnt);
      has = 1'b0;
      ek  = 3'b000;
      while (exp_q[d].size() != 0 && exp_q[d][0].cyc < cyc) begin
        e = exp_q[d].pop_front();
        check({p, "_missed_event_cycle"}, 32'(cyc), 32'(e.cyc));
      end
      if (exp_q[d].size() != 0 && exp_q[d][0].cyc == cyc) begin
        e   = exp_q[d].pop_front();
        has = 1'b1;
        ek  = e.kind;
      end
      if (ev != 3'b000 || has) begin
        check({p, "_event"}, 32'(ev), 32'(ek));
        if (has) begin
          check({p, "_word"}, w, e.word);
          check({p, "_cnt"},  c, e.cnt);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  int wrap_exp[5] = '{1, 2, 3, 0, 1};

  initial begin
    rst     = 1'b1;
    frame   = 1'b0;
    stb     = 1'b0;
    byte_in = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

`ifdef BYTE_TO_SMP_CHECKSUM_EN
    drive(1, 0, 8'h00);
    drive(1, 1, 8'h34); drive(1, 1, 8'h12); drive(1, 1, 8'h26);
    check("chk_b_word_ok",  32'(b_word),  32'h234);
    check("chk_b_valid_ok", 32'(b_valid), 32'h1);
    drive(1, 1, 8'h34); drive(1, 1, 8'h12); drive(1, 1, 8'h00);
    check("chk_b_err_pulse", 32'(b_chk),   32'h1);
    check("chk_b_err_word",  32'(b_word),  32'h234);
    check("chk_b_err_cnt",   32'(b_cnt),   32'h1);
    check("chk_b_err_valid", 32'(b_valid), 32'h0);
    drive(0, 0, 8'h00);
`else
    // Basic 24-bit word with a one-cycle valid pulse.
    drive(1, 0, 8'h00);
    drive(1, 1, 8'h11); drive(1, 1, 8'h22); drive(1, 1, 8'h33);
    check("a_word_332211", 32'(a_word),  32'h33_2211);
    check("a_valid_pulse", 32'(a_valid), 32'h1);
    check("a_cnt_one",     32'(a_cnt),   32'h1);
    drive(1, 0, 8'h00);
    check("a_valid_1cyc",  32'(a_valid), 32'h0);
    drive(0, 0, 8'h00);

    // 12-bit word: the pad nibble of the second byte is discarded.
    drive(1, 1, 8'hBC); drive(1, 1, 8'hFA);
    check("b_word_abc",    32'(b_word),  32'hABC);
    check("b_valid_abc",   32'(b_valid), 32'h1);
    drive(0, 0, 8'h00);

    // Partial word aborted, then a clean frame.
    drive(1, 1, 8'h01); drive(1, 1, 8'h02); drive(0, 0, 8'h00);
    check("a_partial_drop", 32'(a_drop), 32'h1);
    check("a_drop_word",    32'(a_word), 32'h33_2211);
    check("a_drop_cnt",     32'(a_cnt),  32'h1);
    drive(0, 0, 8'h00);
    check("a_drop_1cyc",    32'(a_drop), 32'h0);
    drive(1, 1, 8'hAA); drive(1, 1, 8'hBB); drive(1, 1, 8'hCC);
    check("a_word_ccbbaa",  32'(a_word), 32'hCC_BBAA);
    drive(0, 0, 8'h00);

    // Back-to-back strobes across a word boundary.
    do_reset();
    drive(1, 0, 8'h00);
    for (int i = 1; i <= 6; i++) begin
      drive(1, 1, 8'(i));
      if (i == 3) check("a_b2b_word1", 32'(a_word), 32'h03_0201);
    end
    check("a_b2b_word2", 32'(a_word),  32'h06_0504);
    check("a_b2b_valid", 32'(a_valid), 32'h1);
    check("a_b2b_cnt",   32'(a_cnt),   32'h2);
    drive(0, 0, 8'h00);

    // Counter wrap on the 2-bit instance.
    do_reset();
    drive(1, 0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 8'($urandom_range(0, 255)));
      drive(1, 1, 8'($urandom_range(0, 255)));
      check("b_cnt_wrap", 32'(b_cnt), 32'(wrap_exp[k]));
    end
    drive(0, 0, 8'h00);

    // Final byte coincides with the frame falling.
    drive(1, 1, 8'h41); drive(1, 1, 8'h42); drive(0, 1, 8'h43);
    check("a_fall_valid", 32'(a_valid), 32'h1);
    check("a_fall_drop",  32'(a_drop),  32'h0);
    check("a_fall_word",  32'(a_word),  32'h43_4241);
    drive(0, 0, 8'h00);
    check("a_fall_nodrop_next", 32'(a_drop), 32'h0);

    // Reset in the middle of a word; do_reset checks outputs before any edge.
    drive(1, 1, 8'h55); drive(1, 1, 8'h66);
    do_reset();
`endif

    // Randomized traffic.
    begin
      bit f = 1'b0;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 15) == 0) f = ~f;
        drive(f, $urandom_range(0, 2) != 0, 8'($urandom_range(0, 255)));
      end
    end
    drive(0, 0, 8'h00);
    drive(0, 0, 8'h00);
    drive(0, 0, 8'h00);
    check("a_pending_events", 32'(exp_q[0].size()), 32'h0);
    check("b_pending_events", 32'(exp_q[1].size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
